// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter between
// instruction fetch (IF) and load/store (D).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IF requester, D requester and memory-side signals.
// Handshake: a requester holds req and its fields stable until gnt pulses;
// gnt means memory took the request; rvalid pulses once per granted request.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_gnt, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    // Environment view (requesters plus memory)
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_gnt, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       winner
);

    always_comb begin
        grant_valid = |req;
        winner      = OWNER_IF;
        case (req)
            2'b01:   winner = OWNER_IF;
            2'b10:   winner = OWNER_D;
            2'b11:   winner = ~last;
            default: winner = OWNER_IF;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and
// load/store, with a response-timeout watchdog.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_REQ      = REQ;
    localparam logic [1:0] S_WAIT_RSP = WAIT_RSP;

    logic [1:0]          state;
    logic                owner;
    logic                last_owner;
    logic [CNT_W-1:0]    cnt;

    logic                m_req_q;
    logic                m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W/8-1:0] m_wstrb_q;

    logic                grant_valid;
    logic                winner;
    logic                gnt_fire;
    logic                timeout_hit;
    logic                rsp_done;
    logic [DATA_W-1:0]   rsp_data;

    rr_arb2 u_rr_arb2 (
        .req         ({bus.d_req, bus.if_req}),
        .last        (last_owner),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // A real response in the timeout cycle wins over the forced error.
    assign gnt_fire    = (state == S_REQ) && bus.m_gnt;
    assign timeout_hit = (state == S_WAIT_RSP) && !bus.m_rvalid && (cnt == CNT_W'(TIMEOUT));
    assign rsp_done    = (state == S_WAIT_RSP) && (bus.m_rvalid || timeout_hit);
    assign rsp_data    = bus.m_rvalid ? bus.m_rdata : DATA_W'(TIMEOUT_RDATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWNER_IF;
            last_owner <= OWNER_D;
            cnt        <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner   <= winner;
                        m_req_q <= 1'b1;
                        // Fetches are always plain reads.
                        if (winner == OWNER_D) begin
                            m_we_q    <= bus.d_we;
                            m_addr_q  <= bus.d_addr;
                            m_wdata_q <= bus.d_wdata;
                            m_wstrb_q <= bus.d_wstrb;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= bus.if_addr;
                            m_wdata_q <= '0;
                            m_wstrb_q <= '0;
                        end
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.m_gnt) begin
                        m_req_q    <= 1'b0;
                        last_owner <= owner;
                        cnt        <= '0;
                        state      <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_done) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;

    assign bus.if_gnt    = gnt_fire && (owner == OWNER_IF);
    assign bus.d_gnt     = gnt_fire && (owner == OWNER_D);
    assign bus.if_rvalid = rsp_done && (owner == OWNER_IF);
    assign bus.d_rvalid  = rsp_done && (owner == OWNER_D);
    assign bus.if_rdata  = bus.if_rvalid ? rsp_data : '0;
    assign bus.d_rdata   = bus.d_rvalid ? rsp_data : '0;
    assign bus.if_err    = bus.if_rvalid && timeout_hit;
    assign bus.d_err     = bus.d_rvalid && timeout_hit;

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model of
// the arbitration, grant, response and timeout rules.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int exp_rsp = 0;
    int obs_rsp = 0;
    logic [AW-1:0] exp_q[$];

    // Reference transaction: one latched request, granted or not yet.
    bit            t_busy, t_granted, t_owner, t_last, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [3:0]    t_wstrb;
    int            t_wait;
    bit            if_gnt_seen, d_gnt_seen;

    // Memory and stimulus knobs (percentages)
    bit mem_pend, mem_mute;
    int mem_dly;
    int p_if, p_d, p_gnt, p_stray;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        t_busy = 0; t_granted = 0; t_owner = OWNER_IF; t_last = OWNER_D;
        t_wait = 0; if_gnt_seen = 0; d_gnt_seen = 0; mem_pend = 0;
        exp_q.delete();
    endtask

    task automatic check_all_zero();
        check("rst_m_req",     bus.m_req,     0);
        check("rst_m_we",      bus.m_we,      0);
        check("rst_m_addr",    bus.m_addr,    0);
        check("rst_m_wdata",   bus.m_wdata,   0);
        check("rst_m_wstrb",   bus.m_wstrb,   0);
        check("rst_if_gnt",    bus.if_gnt,    0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_if_rdata",  bus.if_rdata,  0);
        check("rst_if_err",    bus.if_err,    0);
        check("rst_d_gnt",     bus.d_gnt,     0);
        check("rst_d_rvalid",  bus.d_rvalid,  0);
        check("rst_d_rdata",   bus.d_rdata,   0);
        check("rst_d_err",     bus.d_err,     0);
        check("rst_busy",      busy,          0);
        check("rst_dbg_state", dbg_state,     IDLE);
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic cycle_check();
        bit e_req, e_ig, e_dg, e_to, e_done, e_iv, e_dv;
        logic [DW-1:0] e_data;
        e_req  = t_busy && !t_granted;
        e_ig   = e_req && bus.m_gnt && (t_owner == OWNER_IF);
        e_dg   = e_req && bus.m_gnt && (t_owner == OWNER_D);
        e_to   = t_busy && t_granted && !bus.m_rvalid && (t_wait == TO);
        e_done = t_busy && t_granted && (bus.m_rvalid || e_to);
        e_iv   = e_done && (t_owner == OWNER_IF);
        e_dv   = e_done && (t_owner == OWNER_D);
        e_data = bus.m_rvalid ? bus.m_rdata : TIMEOUT_RDATA;

        check("m_req", bus.m_req, e_req);
        if (e_req) begin
            check("m_addr",  bus.m_addr,  t_addr);
            check("m_we",    bus.m_we,    t_we);
            check("m_wdata", bus.m_wdata, t_wdata);
            check("m_wstrb", bus.m_wstrb, t_wstrb);
        end
        check("if_gnt",    bus.if_gnt,    e_ig);
        check("d_gnt",     bus.d_gnt,     e_dg);
        check("if_rvalid", bus.if_rvalid, e_iv);
        check("d_rvalid",  bus.d_rvalid,  e_dv);
        check("if_err",    bus.if_err,    e_iv && e_to);
        check("d_err",     bus.d_err,     e_dv && e_to);
        if (e_iv) check("if_rdata", bus.if_rdata, e_data);
        if (e_dv && !t_we) check("d_rdata", bus.d_rdata, e_data);
        check("busy", busy, t_busy);

        if (bus.if_rvalid || bus.d_rvalid) obs_rsp++;
        if (e_done) exp_rsp++;

        if (e_req && bus.m_gnt) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_addr", bus.m_addr, exp_q.pop_front());
        end

        if_gnt_seen = e_ig;
        d_gnt_seen  = e_dg;
        if (!t_busy) begin
            if (bus.if_req || bus.d_req) begin
                t_owner = (bus.if_req && bus.d_req) ? !t_last : bus.d_req;
                if (t_owner == OWNER_D) begin
                    t_addr = bus.d_addr; t_we = bus.d_we; t_wdata = bus.d_wdata; t_wstrb = bus.d_wstrb;
                end else begin
                    t_addr = bus.if_addr; t_we = 0; t_wdata = '0; t_wstrb = '0;
                end
                exp_q.push_back(t_addr);
                t_busy = 1; t_granted = 0;
            end
        end else if (!t_granted) begin
            if (bus.m_gnt) begin
                t_granted = 1; t_last = t_owner; t_wait = 0;
                mem_pend = !mem_mute;
                mem_dly  = $urandom_range(0, 3);
            end
        end else if (e_done) begin
            t_busy = 0;
        end else begin
            t_wait++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        if (!(bus.if_req && !if_gnt_seen)) begin
            bus.if_req = ($urandom_range(0, 99) < p_if);
            if (bus.if_req) bus.if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
        end
        if (!(bus.d_req && !d_gnt_seen)) begin
            bus.d_req = ($urandom_range(0, 99) < p_d);
            if (bus.d_req) begin
                bus.d_we    = $urandom_range(0, 1);
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_wstrb = 4'($urandom_range(0, 15));
            end
        end
        bus.m_gnt   = ($urandom_range(0, 99) < p_gnt);
        bus.m_rdata = $urandom;
        if (mem_pend) begin
            if (mem_dly == 0) begin
                bus.m_rvalid = 1'b1;
                mem_pend     = 0;
            end else begin
                bus.m_rvalid = 1'b0;
                mem_dly--;
            end
        end else begin
            // Stray responses only where the arbiter must ignore them.
            bus.m_rvalid = !(t_busy && t_granted) && ($urandom_range(0, 99) < p_stray);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_check();
            @(posedge clk); #1;
            drive_inputs();
            @(negedge clk);
        end
    endtask

    task automatic set_knobs(input int pi, input int pd, input int pg, input int ps, input bit mute);
        p_if = pi; p_d = pd; p_gnt = pg; p_stray = ps; mem_mute = mute;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();

        // Both requesters pending at reset release: fetch first, then alternate.
        set_knobs(100, 100, 100, 0, 0);
        bus.if_req = 1; bus.if_addr = 32'h0000_0010;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0100;
        @(negedge clk);
        rst = 1;
        run(40);

        set_knobs(40, 40, 50, 20, 0);
        run(1500);
        set_knobs(50, 60, 15, 10, 0);
        run(800);
        set_knobs(40, 40, 100, 20, 1);
        run(150);
        set_knobs(40, 40, 60, 30, 0);
        run(200);

        // Async reset while waiting on a silent memory.
        set_knobs(100, 0, 100, 0, 1);
        for (int i = 0; i < 60 && !(t_busy && t_granted); i++) run(1);
        check("reach_wait_rsp", t_busy && t_granted, 1);
        run(2);
        @(posedge clk); #3;
        rst = 0;
        #1;
        check_all_zero();
        bus.if_req = 0; bus.d_req = 0; bus.m_gnt = 0;
        bus.m_rvalid = 1; bus.m_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1;
        model_reset();
        set_knobs(100, 0, 100, 0, 0);
        run(20);
        set_knobs(30, 70, 70, 10, 0);
        run(300);

        check("rsp_count", obs_rsp, exp_rsp);
        check("activity", exp_rsp > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
